// File: rtl/camera_pkg.sv
// rtl/camera_pkg.sv - shared widths, FSM states and readout word layout for adc_readout
package camera_pkg;

    localparam int DATA_W = 8;
    localparam int COLS   = 2;
    localparam int COL_W  = $clog2(COLS);

    localparam logic [DATA_W-1:0] MAX_CODE = {DATA_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        STORE   = 2'd2
    } state_t;

    typedef struct packed {
        logic              row;
        logic [COL_W-1:0]  col;
        logic [DATA_W-1:0] value;
    } word_t;

endpackage

// File: rtl/adc_readout_if.sv
// rtl/adc_readout_if.sv - readout word stream from adc_readout to the image sink
interface adc_readout_if #(
    parameter int WORD_W = camera_pkg::DATA_W + 1 + $clog2(camera_pkg::COLS)
);

    logic [WORD_W-1:0] Data_out;
    logic              Data_valid;
    logic              Data_ready;

    modport master (output Data_out, output Data_valid, input Data_ready);
    modport slave  (input Data_out, input Data_valid, output Data_ready);

endinterface

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous FIFO buffering readout words ahead of the sink
module pixel_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit tells full from empty when the indices coincide.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/adc_readout.sv
// rtl/adc_readout.sv - single-slope column conversion driven by row strobes and the ADC window,
// with tagged per-column results streamed out through pixel_fifo
module adc_readout #(
    parameter int DATA_W     = camera_pkg::DATA_W,
    parameter int COLS       = camera_pkg::COLS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              NRE_1,
    input  logic              NRE_2,
    input  logic              ADC,
    input  logic              Expose,
    input  logic              Erase,
    input  logic [COLS-1:0]   Cmp,
    output logic [DATA_W-1:0] Ramp,
    output logic              Busy,
    output logic              Row_error,
    output logic              Overrun,
    adc_readout_if.master     stream
);

    import camera_pkg::*;

    localparam int COL_W  = $clog2(COLS);
    localparam int WORD_W = DATA_W + 1 + COL_W;
    localparam logic [DATA_W-1:0] RAMP_MAX = {DATA_W{1'b1}};

    state_t            state;
    state_t            state_nx;
    logic              adc_q;
    logic              adc_rise;
    logic              adc_fall;
    logic              adc_ok;
    logic              row_ok;
    logic              conv_done;
    logic              store_last;
    logic              start;
    logic              bad_row;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              row_q;
    logic [COLS-1:0]   tripped;
    logic [DATA_W-1:0] col_val [COLS];
    logic [COL_W-1:0]  store_idx;
    logic [WORD_W-1:0] push_word;

    assign adc_rise   = ADC && !adc_q;
    assign adc_fall   = !ADC && adc_q;
    assign adc_ok     = adc_rise && !Expose;
    assign row_ok     = NRE_1 ^ NRE_2;
    assign conv_done  = adc_fall || (Ramp == RAMP_MAX);
    assign store_last = (store_idx == COL_W'(COLS - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (adc_ok && row_ok) state_nx = CONVERT;
            CONVERT: if (conv_done)        state_nx = STORE;
            STORE:   if (store_last)       state_nx = IDLE;
            default:                       state_nx = IDLE;
        endcase
    end

    always_comb begin
        Busy    = 1'b0;
        start   = 1'b0;
        bad_row = 1'b0;
        push    = 1'b0;
        case (state)
            IDLE: begin
                start   = adc_ok && row_ok;
                bad_row = adc_ok && !row_ok;
            end
            CONVERT: Busy = 1'b1;
            STORE: begin
                Busy = 1'b1;
                push = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            adc_q     <= 1'b0;
            Ramp      <= '0;
            row_q     <= 1'b0;
            tripped   <= '0;
            store_idx <= '0;
            Row_error <= 1'b0;
            Overrun   <= 1'b0;
            for (int c = 0; c < COLS; c++) col_val[c] <= '0;
        end else begin
            adc_q     <= ADC;
            Row_error <= bad_row;
            if (start) begin
                Ramp      <= '0;
                row_q     <= NRE_1;
                tripped   <= '0;
                store_idx <= '0;
            end else if (state == CONVERT) begin
                if (Ramp != RAMP_MAX) Ramp <= Ramp + 1'b1;
                // A trip in the exit cycle still wins over the saturated fill.
                for (int c = 0; c < COLS; c++) begin
                    if (Cmp[c] && !tripped[c]) begin
                        col_val[c] <= Ramp;
                        tripped[c] <= 1'b1;
                    end else if (conv_done && !tripped[c]) begin
                        col_val[c] <= RAMP_MAX;
                    end
                end
            end else if (state == STORE) begin
                store_idx <= store_idx + 1'b1;
            end
            if (Erase)
                Overrun <= 1'b0;
            else if ((adc_rise && Busy) || (push && fifo_full && !pop))
                Overrun <= 1'b1;
        end
    end

    assign push_word = {row_q, store_idx, col_val[store_idx]};
    assign pop       = stream.Data_valid && stream.Data_ready;

    assign stream.Data_valid = !fifo_empty;

    pixel_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (Clk),
        .rst       (Reset),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (stream.Data_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: doc/adc_readout.md
# adc_readout

Readout-side counterpart of the exposure controller. It consumes the row strobes NRE_1/NRE_2 and the ADC phase signal and runs a single-slope conversion: it drives the ramp-DAC code, times the column comparator trips, and captures one digital value per column. Each captured row is tagged and streamed out through a small FIFO with a valid/ready handshake. It sits between the exposure controller and the pixel-array analog front end on one side, and the image sink on the other.

## Interface
- DATA_W, 8: ramp/pixel value width.
- COLS, 2: number of column comparators, one pixel per column per row.
- FIFO_DEPTH, 4: output buffer entries; power of two, at least 2.
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- NRE_1  input  1  row-1 readout enable, active low.
- NRE_2  input  1  row-2 readout enable, active low.
- ADC  input  1  conversion window from the exposure controller, active high.
- Expose  input  1  exposure in progress; conversion starts are blocked while high.
- Erase  input  1  frame erase; clears the sticky flags.
- Cmp  input  COLS  column comparator outputs; 1 = ramp has passed the pixel voltage.
- Ramp  output  DATA_W  ramp-DAC code.
- Busy  output  1  high in CONVERT and STORE.
- Data_out  output  DATA_W+1+clog2(COLS)  word {row, col, value}; row 0 = NRE_1.
- Data_valid  output  1  FIFO not empty.
- Data_ready  input  1  sink accepts Data_out.
- Row_error  output  1  one-cycle pulse, illegal strobe combination.
- Overrun  output  1  sticky; a word or a conversion was lost.

## Operation
- States: IDLE, CONVERT, STORE.
- IDLE -> CONVERT on an ADC rising edge when all of the following hold:
  - ADC is sampled high this cycle and was low the previous cycle;
  - Expose = 0;
  - exactly one of NRE_1/NRE_2 is low.
- On that transition, latch the row, clear Ramp to 0, and clear the per-column trip flags.
- ADC rising edge with NRE_1 = NRE_2 (both low or both high): pulse Row_error, stay in IDLE.
- ADC rising edge with Expose = 1: ignore it.
- CONVERT:
  - Ramp increments by 1 each cycle and saturates at 2^DATA_W-1; it never wraps.
  - In the first cycle Cmp[c] = 1 with the column's flag clear, latch the current Ramp into column c's register and set the flag.
  - Later comparator activity is ignored.
- CONVERT -> STORE on the first of: ADC falling edge, or Ramp at max.
- Every column not tripped on exit stores 2^DATA_W-1 (saturated pixel).
- STORE: push one word per cycle for columns 0..COLS-1 in order, then return to IDLE.
- A push while the FIFO is full, with no pop that cycle, drops the word and sets Overrun.
- An ADC rising edge while Busy is not a new conversion; it sets Overrun.
- Overrun clears on Reset or when Erase = 1.

## Timing
- Reset values:
  - state IDLE, Ramp 0, Busy 0;
  - Data_valid 0, Data_out 0;
  - Row_error 0, Overrun 0;
  - FIFO empty, column registers 0.
- Edge detection uses a registered copy of ADC. CONVERT is entered the cycle after ADC is first seen high, and Ramp = 0 in that first CONVERT cycle.
- Comparator-to-capture: a Cmp sampled high at Ramp = k stores k.
- STORE lasts exactly COLS cycles.
- The first word appears on Data_valid the cycle after its push; there is no combinational bypass.
- Handshake: a transfer occurs when Data_valid && Data_ready on a rising edge. Data_out must stay stable while Data_valid && !Data_ready.
- Simultaneous push and pop on a full FIFO: both succeed, with no Overrun.
- Simultaneous push and pop on an empty FIFO: the push succeeds and Data_valid rises next cycle.
- Reset mid-conversion or mid-STORE returns to IDLE immediately and flushes the FIFO.

## Structure
- camera_pkg holds:
  - DATA_W;
  - the state enum (IDLE/CONVERT/STORE);
  - the readout word struct {row, col, value};
  - the max-code constant.
- Sub-module pixel_fifo: synchronous FIFO with an async active-high Reset, push/pop/full/empty, parameterised on word width and FIFO_DEPTH.
- The top level holds the FSM, the ramp counter, the edge detector and the column registers.

## Test plan
- NRE_1 = 0, ADC high for 300 cycles, Cmp[0] rises at Ramp = 37, Cmp[1] at 200, Data_ready = 1 -> words {0,0,37} then {0,1,200}; Busy drops after 258 cycles.
- NRE_2 = 0, ADC falls at Ramp = 50, Cmp[1] never trips -> {1,0,x} as captured, {1,1,255}.
- ADC rises with NRE_1 = NRE_2 = 0 -> one Row_error pulse; Busy stays 0; no words.
- Data_ready = 0 for three conversions (6 words, FIFO_DEPTH = 4) -> 4 words retained, Overrun = 1; Erase pulse clears Overrun; the 4 words drain in order.
- ADC rises while Expose = 1 -> no conversion, Ramp stays 0.
- Reset asserted at Ramp = 100 -> Ramp = 0, Busy = 0, Data_valid = 0 immediately, with no clock required.
